// File: rtl/if_fetch.sv
// Instruction fetch stage: credit-limited request issue to instruction memory,
// in-order response pairing, a small instruction buffer and redirect flushing.
`timescale 1ns/1ps
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready
);
  localparam int             CW       = $clog2(DEPTH + 1);
  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]    DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
  localparam logic [31:0]    NOP      = 32'h0000_0013;

  // Handshakes: a transfer happens on any cycle where valid && ready are both high;
  // responses carry no ready and are accepted whenever a fetch is outstanding.

  logic [63:0]   fetch_pc;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_count;

  logic [63:0]   req_addr_q [DEPTH];
  logic [PW-1:0] req_wr_ptr;
  logic [PW-1:0] req_rd_ptr;

  logic [31:0]   buf_data [DEPTH];
  logic [63:0]   buf_pc   [DEPTH];
  logic [PW-1:0] buf_wr_ptr;
  logic [PW-1:0] buf_rd_ptr;

  logic req_fire;
  logic resp_fire;
  logic resp_keep;
  logic resp_drop;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Buffer slots are reserved at issue time, so a kept response always has room.
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, buf_count} + {1'b0, inflight}) < DEPTH_W);
  assign imem_req_addr  = fetch_pc;

  assign instr_valid = !rst && (buf_count != '0);
  assign instr       = instr_valid ? buf_data[buf_rd_ptr] : NOP;
  assign instr_pc    = instr_valid ? buf_pc[buf_rd_ptr]   : '0;

  always_comb begin
    req_fire  = imem_req_valid && imem_req_ready;
    resp_fire = imem_resp_valid && (inflight != '0);
    resp_drop = resp_fire && (drop_count != '0);
    resp_keep = resp_fire && (drop_count == '0) && !redirect_valid;
    pop       = instr_valid && instr_ready && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC & ~64'h3;
      buf_count  <= '0;
      inflight   <= '0;
      drop_count <= '0;
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc   <= fetch_pc + 64'd4;
        req_wr_ptr <= ptr_inc(req_wr_ptr);
      end
      if (resp_fire) req_rd_ptr <= ptr_inc(req_rd_ptr);
      inflight <= inflight + CW'(req_fire) - CW'(resp_fire);

      // Responses still outstanding at a redirect belong to the old path.
      if (redirect_valid) begin
        fetch_pc   <= redirect_pc & ~64'h3;
        buf_count  <= '0;
        buf_wr_ptr <= '0;
        buf_rd_ptr <= '0;
        drop_count <= inflight - CW'(resp_fire);
      end else begin
        if (resp_drop) drop_count <= drop_count - CW'(1);
        if (resp_keep) buf_wr_ptr <= ptr_inc(buf_wr_ptr);
        if (pop)       buf_rd_ptr <= ptr_inc(buf_rd_ptr);
        buf_count <= buf_count + CW'(resp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) req_addr_q[req_wr_ptr] <= fetch_pc;
    if (resp_keep) begin
      buf_data[buf_wr_ptr] <= imem_resp_data;
      buf_pc[buf_wr_ptr]   <= req_addr_q[req_rd_ptr];
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: behavioural instruction memory with fixed latency,
// directed scenarios and a scoreboard of expected {instr, pc} deliveries.
`timescale 1ns/1ps
module tb_if_fetch;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready = 1'b0;

  typedef struct {
    int          due;
    logic [63:0] addr;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] req_log[$];
  logic [95:0] exp_q[$];
  int cyc = 0;
  int lat = 1;
  int n_tests = 0;
  int n_fail = 0;
  bit spur_resp = 1'b0;
  bit rand_ready = 1'b0;

  if_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h0050_0093 + {20'h0, a[11:0]};
  endfunction

  // ---------------- instruction memory model ----------------
  always @(negedge clk) begin
    #1;
    if (spur_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hdead_beef;
    end else if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{due: cyc + lat, addr: imem_req_addr});
      req_log.push_back(imem_req_addr);
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [95:0] e;
    #2;
    if (!rst && instr_valid && instr_ready && !redirect_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL instr_stream: unexpected instr=%h pc=%h, nothing expected", instr, instr_pc);
      end else begin
        e = exp_q.pop_front();
        if ({instr, instr_pc} !== e) begin
          n_fail++;
          $display("FAIL instr_stream: got instr=%h pc=%h expected instr=%h pc=%h",
                   instr, instr_pc, e[95:64], e[63:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_seq(input logic [63:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] pc;
      pc = pc0 + 64'(4 * i);
      exp_q.push_back({mem_word(pc), pc});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the start of the first cycle after reset.
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b1;
    spur_resp = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 0);
    @(negedge clk);
    #3;
    mem_q.delete();
    req_log.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      if (rand_ready) imem_req_ready = 1'($urandom_range(0, 1));
    end
    instr_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d instructions still pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // basic streaming, 1-cycle memory
    lat = 1;
    do_reset();
    instr_ready = 1'b1;
    push_seq(RESET_PC, 6);
    #1;
    check("t1_req_valid_c0", imem_req_valid, 1);
    check("t1_req_addr_c0", imem_req_addr, RESET_PC);
    check("t1_instr_valid_c0", instr_valid, 0);
    step(1); #1;
    check("t1_instr_valid_c1", instr_valid, 0);
    step(1); #1;
    check("t1_instr_valid_c2", instr_valid, 1);
    check("t1_instr_pc_c2", instr_pc, RESET_PC);
    wait_drain(60);
    check("t1_req0", req_log[0], RESET_PC);
    check("t1_req1", req_log[1], RESET_PC + 64'd4);

    // decoder stalled: buffer fills, issue stops, then resumes
    lat = 1;
    do_reset();
    step(4); #1;
    check("t2_req_valid_full", imem_req_valid, 0);
    check("t2_req_count", 64'(req_log.size()), 2);
    check("t2_req1", req_log[1], RESET_PC + 64'd4);
    check("t2_head_pc", instr_pc, RESET_PC);
    push_seq(RESET_PC, 6);
    instr_ready = 1'b1;
    wait_drain(60);
    check("t2_req2", req_log[2], RESET_PC + 64'd8);

    // redirect with two fetches in flight, none returning that cycle
    lat = 3;
    do_reset();
    instr_ready = 1'b1;
    push_seq(64'h8000_1000, 4);
    step(2);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1003;
    #1;
    check("t3_req_stall", imem_req_valid, 0);
    step(1);
    redirect_valid = 1'b0;
    wait_drain(60);
    check("t3_req2", req_log[2], 64'h8000_1000);

    // redirect together with a response and a pop
    lat = 1;
    do_reset();
    instr_ready = 1'b1;
    push_seq(64'h8000_2000, 3);
    step(2);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_2000;
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("t4_instr_valid", instr_valid, 0);
    check("t4_instr_nop", instr, NOP);
    check("t4_instr_pc", instr_pc, 0);
    check("t4_req_valid", imem_req_valid, 1);
    check("t4_req_addr", imem_req_addr, 64'h8000_2000);
    wait_drain(60);

    // redirect on the cycle one of two in-flight responses arrives
    lat = 3;
    do_reset();
    instr_ready = 1'b1;
    push_seq(64'h8000_4000, 3);
    step(3);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_4000;
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("t5_req_valid", imem_req_valid, 1);
    check("t5_req_addr", imem_req_addr, 64'h8000_4000);
    wait_drain(60);

    // redirect right after reset, then random memory ready with 3-cycle latency
    lat = 3;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_3000;
    #1;
    check("t6_req_stall", imem_req_valid, 0);
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("t6_req_valid", imem_req_valid, 1);
    check("t6_req_addr", imem_req_addr, 64'h8000_3000);
    push_seq(64'h8000_3000, 16);
    instr_ready = 1'b1;
    rand_ready = 1'b1;
    wait_drain(400);
    rand_ready = 1'b0;

    // reset with one buffered and one in flight
    lat = 2;
    do_reset();
    step(3);
    do_reset();
    #1;
    check("t7_instr_valid", instr_valid, 0);
    check("t7_req_valid", imem_req_valid, 1);
    check("t7_req_addr", imem_req_addr, RESET_PC);
    push_seq(RESET_PC, 3);
    instr_ready = 1'b1;
    wait_drain(60);

    // spurious response with nothing outstanding is ignored
    lat = 1;
    do_reset();
    imem_req_ready = 1'b0;
    spur_resp = 1'b1;
    step(1);
    spur_resp = 1'b0;
    step(1); #1;
    check("t8_instr_valid", instr_valid, 0);
    check("t8_req_valid", imem_req_valid, 1);
    check("t8_req_addr", imem_req_addr, RESET_PC);
    imem_req_ready = 1'b1;
    push_seq(RESET_PC, 2);
    instr_ready = 1'b1;
    wait_drain(60);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
